// File: rtl/spart_rx_os.sv
// spart_rx_os: oversampling SPART receiver with majority-vote bit recovery,
// optional parity, 1 or 2 stop bits, FWFT receive FIFO and sticky error flags.
module spart_rx_os #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OS_RATE    = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rxd,
  input  logic [15:0]                        divisor_buffer,
  input  logic [1:0]                         parity_mode,
  input  logic                               rd_en,
  input  logic                               err_clr,
  output logic [DATA_W-1:0]                  rx_data,
  output logic                               rda,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               parity_err,
  output logic                               framing_err,
  output logic                               overrun_err
);

  localparam int unsigned OW = $clog2(OS_RATE);
  localparam int unsigned BW = $clog2(DATA_W);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  localparam logic [OW-1:0] OsV0    = OW'(OS_RATE / 2 - 1);
  localparam logic [OW-1:0] OsV1    = OW'(OS_RATE / 2);
  localparam logic [OW-1:0] OsV2    = OW'(OS_RATE / 2 + 1);
  localparam logic [OW-1:0] OsLast  = OW'(OS_RATE - 1);
  localparam logic [BW-1:0] BitLast = BW'(DATA_W - 1);
  localparam logic          StopLast = 1'(STOP_BITS - 1);
  localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic              meta_q, rxs_q;
  logic [15:0]       tick_cnt_q;
  logic              tick, start_det;
  logic [OW-1:0]     os_cnt_q, os_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              v0_q, v0_d, v1_q, v1_d;
  logic              par_bad_q, par_bad_d;
  logic              stop_bad_q, stop_bad_d;
  logic              voted, vote_tick, wrap, parity_on;
  logic              frame_done, frame_bad;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              push_req, push, pop, full, overrun_evt;

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= rxd;
      rxs_q  <= meta_q;
    end
  end

  assign tick      = (tick_cnt_q == '0);
  assign start_det = (state_q == StIdle) && !rxs_q;

  // Oversample tick down-counter; realigned to the start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= divisor_buffer;
    end else if (start_det || tick) begin
      tick_cnt_q <= divisor_buffer;
    end else begin
      tick_cnt_q <= tick_cnt_q - 16'd1;
    end
  end

  assign voted     = (v0_q & v1_q) | (v0_q & rxs_q) | (v1_q & rxs_q);
  assign vote_tick = tick && (os_cnt_q == OsV2);
  assign wrap      = tick && (os_cnt_q == OsLast);
  assign parity_on = (parity_mode == 2'b01) || (parity_mode == 2'b10);

  // Receive FSM next-state, bit voting and frame completion
  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    frame_done = 1'b0;
    frame_bad  = 1'b0;

    if (state_q != StIdle && tick) begin
      os_cnt_d = os_cnt_q + 1'b1;
      if (os_cnt_q == OsV0) v0_d = rxs_q;
      if (os_cnt_q == OsV1) v1_d = rxs_q;
    end

    unique case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d    = StStart;
          os_cnt_d   = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_bad_d  = 1'b0;
          stop_bad_d = 1'b0;
        end
      end
      StStart: begin
        if (vote_tick && voted) state_d = StIdle;
        else if (wrap)          state_d = StData;
      end
      StData: begin
        if (vote_tick) shreg_d = {voted, shreg_q[DATA_W-1:1]};
        if (wrap) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = parity_on ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (vote_tick) begin
          par_bad_d = (parity_mode == 2'b01) ? (voted != ^shreg_q) : (voted != ~^shreg_q);
        end
        if (wrap) state_d = StStop;
      end
      StStop: begin
        if (vote_tick) begin
          if (stop_cnt_q == StopLast) begin
            // Frame ends at the last stop vote, not the bit end
            frame_done = 1'b1;
            frame_bad  = stop_bad_q | ~voted;
            state_d    = StIdle;
          end else begin
            stop_bad_d = stop_bad_q | ~voted;
          end
        end
        if (wrap) stop_cnt_d = stop_cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and datapath state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      v0_q       <= 1'b1;
      v1_q       <= 1'b1;
      par_bad_q  <= 1'b0;
      stop_bad_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      par_bad_q  <= par_bad_d;
      stop_bad_q <= stop_bad_d;
    end
  end

  assign push_req    = frame_done && !frame_bad;
  assign full        = (count_q == CntFull);
  assign pop         = rd_en && (count_q != '0);
  assign push        = push_req && (!full || pop);
  assign overrun_evt = push_req && full && !pop;
  assign rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // FIFO occupancy and registered head word
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    head_d = head_q;
    if (count_d != '0) begin
      // Slot being written this cycle is not yet in mem_q
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? shreg_q : mem_q[rd_ptr_d];
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shreg_q;
  end

  // FIFO pointers, count and head register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (err_clr) begin
        parity_err  <= 1'b0;
        framing_err <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (frame_done && frame_bad) framing_err <= 1'b1;
      if (push_req && par_bad_q)   parity_err  <= 1'b1;
      if (overrun_evt)             overrun_err <= 1'b1;
    end
  end

  assign rx_data    = head_q;
  assign rda        = (count_q != '0);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_spart_rx_os.sv
// Directed bench for spart_rx_os with a scoreboard of expected FIFO words.
module tb_spart_rx_os;

  localparam int BitClk = 256;

  logic        clk = 1'b0;
  logic        rst, rxd, rxd2, rd_en, rd_en2, err_clr;
  logic [15:0] divisor_buffer;
  logic [1:0]  parity_mode;
  logic [7:0]  rx_data, rx_data2;
  logic        rda, rda2, pe, fe, oe, pe2, fe2, oe2;
  logic [2:0]  fifo_count, fifo_count2;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic       model_ovr;
  logic [7:0] words [5];

  always #5 clk = ~clk;

  spart_rx_os #(.DATA_W(8), .OS_RATE(16), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .divisor_buffer(divisor_buffer),
    .parity_mode(parity_mode), .rd_en(rd_en), .err_clr(err_clr),
    .rx_data(rx_data), .rda(rda), .fifo_count(fifo_count),
    .parity_err(pe), .framing_err(fe), .overrun_err(oe)
  );

  spart_rx_os #(.DATA_W(8), .OS_RATE(16), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .rxd(rxd2), .divisor_buffer(divisor_buffer),
    .parity_mode(2'b00), .rd_en(rd_en2), .err_clr(err_clr),
    .rx_data(rx_data2), .rda(rda2), .fifo_count(fifo_count2),
    .parity_err(pe2), .framing_err(fe2), .overrun_err(oe2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input bit which, input logic v);
    if (which) rxd2 = v;
    else       rxd  = v;
  endtask

  task automatic hold(input logic v, input bit which, input int nbits);
    set_line(which, v);
    repeat (nbits * BitClk) @(negedge clk);
  endtask

  // par < 0 means no parity bit
  task automatic send(input bit which, input logic [7:0] d, input int par,
                      input logic stop_v, input int nstop);
    logic [31:0] p;
    p = par;
    hold(1'b0, which, 1);
    for (int i = 0; i < 8; i++) hold(d[i], which, 1);
    if (par >= 0) hold(p[0], which, 1);
    for (int s = 0; s < nstop; s++) hold(stop_v, which, 1);
    set_line(which, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic sb_push(input logic [7:0] d);
    if (exp_q.size() < 4) exp_q.push_back(d);
    else                  model_ovr = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=scoreboard-empty expected=word", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rda"}, rda, 1);
      check({tag, "_data"}, rx_data, e);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; rxd = 1'b1; rxd2 = 1'b1; rd_en = 1'b0; rd_en2 = 1'b0; err_clr = 1'b0;
    divisor_buffer = 16'h000F; parity_mode = 2'b00; model_ovr = 1'b0;
    words[0] = 8'hA5; words[1] = 8'hE7; words[2] = 8'h24; words[3] = 8'h3C; words[4] = 8'h5A;
    repeat (3) @(negedge clk);
    check("rst_rda", rda, 0);
    check("rst_data", rx_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_errs", {pe, fe, oe}, 0);
    check("rst_rda2", rda2, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Single word, pop, then pop on empty
    send(0, 8'hA5, -1, 1'b1, 1); sb_push(8'hA5);
    check("t1_count", fifo_count, 1);
    pop_check("t1_pop");
    check("t1_rda_after", rda, 0);
    check("t1_count_after", fifo_count, 0);
    check("t1_errs", {pe, fe, oe}, 0);
    rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    check("t1_empty_count", fifo_count, 0);
    check("t1_empty_hold", rx_data, 8'hA5);

    // Back-to-back frames overflow the FIFO
    for (int i = 0; i < 5; i++) begin
      send(0, words[i], -1, 1'b1, 1);
      sb_push(words[i]);
    end
    check("t2_count", fifo_count, 4);
    check("t2_ovr", oe, model_ovr);
    for (int i = 0; i < 4; i++) pop_check("t2_pop");
    check("t2_count_empty", fifo_count, 0);
    pulse_clr();
    check("t2_ovr_clr", oe, 0);

    // Even parity: bad then good, flag sticky
    parity_mode = 2'b01;
    send(0, 8'hE7, 1, 1'b1, 1); sb_push(8'hE7);
    check("t3_pe_set", pe, 1);
    pop_check("t3_pop_e7");
    send(0, 8'h24, 0, 1'b1, 1); sb_push(8'h24);
    check("t3_pe_sticky", pe, 1);
    pop_check("t3_pop_24");
    parity_mode = 2'b00;
    pulse_clr();
    check("t3_pe_clr", pe, 0);

    // Bad stop bit discards the word
    send(0, 8'h24, -1, 1'b0, 1);
    hold(1'b1, 0, 1);
    check("t4_fe", fe, 1);
    check("t4_count", fifo_count, 0);
    send(0, 8'h3C, -1, 1'b1, 1); sb_push(8'h3C);
    pop_check("t4_pop_3c");
    pulse_clr();

    // Short glitch is a false start
    rxd = 1'b0; repeat (48) @(negedge clk); rxd = 1'b1;
    hold(1'b1, 0, 2);
    check("t5_rda", rda, 0);
    check("t5_errs", {pe, fe, oe}, 0);
    rxd2 = 1'b0; repeat (48) @(negedge clk); rxd2 = 1'b1;
    hold(1'b1, 1, 2);
    check("t5_rda2_glitch", rda2, 0);
    send(1, 8'h5A, -1, 1'b1, 2);
    check("t5_rda2", rda2, 1);
    check("t5_count2", fifo_count2, 1);
    check("t5_data2", rx_data2, 8'h5A);
    check("t5_errs2", {pe2, fe2, oe2}, 0);

    // Reset mid-frame with a word already buffered
    send(0, 8'hA5, -1, 1'b1, 1); sb_push(8'hA5);
    check("t6_pre_count", fifo_count, 1);
    hold(1'b0, 0, 1);
    hold(1'b1, 0, 1);
    hold(1'b0, 0, 1);
    rxd = 1'b1;
    repeat (BitClk / 2) @(negedge clk);
    rst = 1'b0; repeat (3) @(negedge clk); rst = 1'b1;
    exp_q.delete();
    check("t6_rst_rda", rda, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_data", rx_data, 0);
    check("t6_rst_errs", {pe, fe, oe}, 0);
    check("t6_rst_rda2", rda2, 0);
    hold(1'b1, 0, 12);
    send(0, 8'h5A, -1, 1'b1, 1); sb_push(8'h5A);
    check("t6_count", fifo_count, 1);
    pop_check("t6_pop_5a");
    check("t6_errs", {pe, fe, oe}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spart_rx_os.md
Name: spart_rx_os

Overview:
Parametrised next-generation SPART receiver. Oversamples rxd at OS_RATE ticks per bit, majority-votes each bit and checks optional parity and 1 or 2 stop bits. Buffers received words in a first-word-fall-through (FWFT) FIFO with sticky error flags. Sits beside spart_tx under spart and takes the same 16-bit divisor_buffer; spart reads it over the databus.

Parameters:
DATA_W, 8, data bits per frame (5..9), LSB first
OS_RATE, 16, oversample ticks per bit (power of 2, >=4)
STOP_BITS, 1, stop bits checked (1 or 2)
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
rxd  input  1  serial input, asynchronous, idles high
divisor_buffer  input  16  oversample tick period minus 1, in clk cycles
parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none
rd_en  input  1  pop FIFO head (ignored when empty)
err_clr  input  1  clears all sticky error flags
rx_data  output  DATA_W  FIFO head word (FWFT)
rda  output  1  FIFO not empty
fifo_count  output  $clog2(FIFO_DEPTH+1)  words held
parity_err  output  1  sticky parity mismatch
framing_err  output  1  sticky stop-bit error
overrun_err  output  1  sticky word dropped on full FIFO

Behaviour:
- Reset (rst=0, async): rx_data=0, rda=0, fifo_count=0, all err flags=0, state IDLE, synchroniser flops=1, tick counter=divisor_buffer.
- rxd passes a 2-flop synchroniser (rxs). This adds 2 clk latency to every edge.
- Tick generator: down-counter. Pulses tick for one clk when it reaches 0, then reloads divisor_buffer; period = divisor_buffer+1 clocks. It free-runs in IDLE. It is reloaded when a start edge is detected, so sampling is aligned to the edge.
- os_cnt counts ticks 0..OS_RATE-1 within a bit.
- Bit value = majority of rxs at ticks OS_RATE/2-1, OS_RATE/2 and OS_RATE/2+1.
- FSM states:
  - IDLE: rxs=0 -> START, os_cnt=0.
  - START: at tick OS_RATE/2+1, voted value 1 -> IDLE (false start, nothing recorded). Voted 0 -> continue; at os_cnt wrap -> DATA.
  - DATA: shift voted bit in LSB first. After DATA_W bits -> PARITY if parity_mode is 01/10, else STOP.
  - PARITY: even mode expects XOR(data) = bit; odd mode expects ~XOR(data) = bit. Mismatch sets an internal flag.
  - STOP: STOP_BITS bits are voted. Frame completes at the vote tick of the last stop bit, then -> IDLE immediately (no wait for the bit end). The next start edge may arrive from that point.
- Frame completion:
  - Any stop bit voted 0: word discarded, framing_err<=1.
  - Otherwise: word pushed, and parity_err<=1 if the internal parity flag is set (word still stored).
  - Push with FIFO full and no simultaneous pop: word dropped, overrun_err<=1.
  - Full FIFO with rd_en in the same cycle as a push: pop and push both take effect; count unchanged; no overrun.
- FIFO is FWFT:
  - rx_data shows the head word 1 clk after the push into an empty FIFO; rda rises in the same cycle.
  - rd_en with rda=1 advances the head in 1 clk.
  - rd_en when empty has no effect; rx_data holds its last value.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count is exact, 0..FIFO_DEPTH.
- Sticky errors: err_clr clears all three flags. A set event in the same cycle as err_clr wins (flag reads 1).
- divisor_buffer changes take effect at the next reload only; no glitch on the current tick.
- Reset mid-frame aborts the frame, empties the FIFO and returns all outputs to reset values.

Test Plan:
- Common setup: divisor_buffer=16'h000F (16 clk/tick, 256 clk/bit), parity none, defaults.
- Send 8'hA5 -> rda=1, rx_data=8'hA5, fifo_count=1 within 10 bit times of the start edge; rd_en pulse -> rda=0, count=0, no errors.
- Send A5, E7, 24, 3C, 5A back-to-back with no reads -> count=4, overrun_err=1; four pops return A5, E7, 24, 3C; err_clr -> overrun_err=0.
- parity_mode=01, send 8'hE7 with parity bit 1 (correct bit is 0) -> parity_err=1, rx_data=8'hE7. Then send 8'h24 with parity bit 0 -> stored, flag stays 1 (sticky).
- Send 8'h24 with stop bit 0 -> framing_err=1, fifo_count unchanged. The next valid frame 8'h3C is received correctly.
- rxd low pulse of 48 clk (3 ticks) -> FSM returns to IDLE, rda stays 0, no errors. Repeat with STOP_BITS=2 and frame 8'h5A -> received.
- Assert rst for 3 clk midway through the DATA bits of 8'hA5 -> all outputs reset. The following 8'h5A frame is received correctly with count=1.
